regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a built-in busy scoreboard, for the pipelined core. It provides NUM_RD addressed read ports and NUM_WR addressed write ports. Reads are registered with same-cycle write bypass, and register 0 is hardwired to zero. A per-register busy bit is set when an instruction issues and cleared on writeback, so issue logic can detect RAW hazards without external tracking.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
//   WORD_SIZE  : default data width
//   NUM_REGS   : default architectural register count
//   AW         : address width derived from NUM_REGS
//   reg_addr_t : register index type
//   word_t     : register data type
package regfile_pkg;

  localparam int WORD_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int AW        = $clog2(NUM_REGS);

  typedef logic [AW-1:0]        reg_addr_t;
  typedef logic [WORD_SIZE-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file. One busy bit per register, set
// by an issuing instruction (reserve) and cleared by its writeback.
// A reserve wins over a same-cycle clear, so the newest producer owns
// the register. Register 0 is never busy.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rsv_en     : reserve request
//   rsv_addr   : register being reserved
//   wr_en      : per-port writeback strobe
//   wr_addr    : per-port writeback address
//   busy_vec   : current busy state (flop outputs)
//   busy_next  : busy state after this cycle's reserve/writeback
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter  int NUM_WR   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rsv_en,
  input  logic [AW-1:0]                  rsv_addr,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic [NUM_REGS-1:0]            busy_next
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_set;

  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en[j] && (wr_addr[j] == AW'(r))) begin
          w_clr[r] = 1'b1;
        end
      end
    end
    if (rsv_en) begin
      w_set[rsv_addr] = 1'b1;
    end
    // set has priority over clear; x0 can never become busy
    busy_next    = (r_busy & ~w_clr) | w_set;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= busy_next;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered, write-first reads
// and an integrated busy scoreboard for RAW hazard detection.
// Register 0 reads as zero, ignores writes and cannot be reserved.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears everything)
//   rd_en     : per-port read request; when low the read outputs hold
//   rd_addr   : per-port read address
//   rd_data   : registered read data (1-cycle latency, write bypass)
//   rd_busy   : registered busy bit of the addressed register, taken
//               after this cycle's reserve/writeback
//   wr_en     : per-port write strobe (highest port wins on conflict)
//   wr_addr   : per-port write address
//   wr_data   : per-port write data
//   rsv_en    : mark rsv_addr busy
//   rsv_addr  : destination register being issued
//   busy_vec  : current scoreboard state
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WORD_SIZE = regfile_pkg::WORD_SIZE,
  parameter  int NUM_REGS  = regfile_pkg::NUM_REGS,
  parameter  int NUM_RD    = 2,
  parameter  int NUM_WR    = 1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RD-1:0]                 rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]         rd_addr,
  output logic [NUM_RD-1:0][WORD_SIZE-1:0]  rd_data,
  output logic [NUM_RD-1:0]                 rd_busy,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]         wr_addr,
  input  logic [NUM_WR-1:0][WORD_SIZE-1:0]  wr_data,
  input  logic                              rsv_en,
  input  logic [AW-1:0]                     rsv_addr,
  output logic [NUM_REGS-1:0]               busy_vec
);

  logic [WORD_SIZE-1:0]              r_regs [NUM_REGS];
  logic [NUM_RD-1:0][WORD_SIZE-1:0]  r_rd_data;
  logic [NUM_RD-1:0]                 r_rd_busy;

  logic [NUM_REGS-1:0]               w_busy_next;
  logic [NUM_REGS-1:0]               w_wr_hit;
  logic [WORD_SIZE-1:0]              w_wr_val [NUM_REGS];
  logic [NUM_RD-1:0][WORD_SIZE-1:0]  w_rd_val;
  logic [NUM_RD-1:0]                 w_rd_bsy;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy_vec  (busy_vec),
    .busy_next (w_busy_next)
  );

  // Write-port resolution: scan ports in ascending order so the
  // highest-indexed port targeting a register overrides the others.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_wr_val[r] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en[j] && (wr_addr[j] == AW'(r))) begin
          w_wr_hit[r] = 1'b1;
          w_wr_val[r] = wr_data[j];
        end
      end
    end
    w_wr_hit[0] = 1'b0;
  end

  // Read selection: write-first bypass so a same-cycle write is seen
  // without waiting for the array update.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_val[i] = '0;
      w_rd_bsy[i] = 1'b0;
      if (rd_addr[i] != '0) begin
        if (w_wr_hit[rd_addr[i]]) begin
          w_rd_val[i] = w_wr_val[rd_addr[i]];
        end else begin
          w_rd_val[i] = r_regs[rd_addr[i]];
        end
        w_rd_bsy[i] = w_busy_next[rd_addr[i]];
      end
    end
  end

  // Storage array and read output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_val[r];
        end
      end
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          r_rd_data[i] <= w_rd_val[i];
          r_rd_busy[i] <= w_rd_bsy[i];
        end
      end
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int RD = 2;
  localparam int WR = 2;
  localparam int AW = 5;

  typedef struct {
    int          port;
    logic [W-1:0] data;
    logic        busy;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [RD-1:0]           rd_en;
  logic [RD-1:0][AW-1:0]   rd_addr;
  logic [RD-1:0][W-1:0]    rd_data;
  logic [RD-1:0]           rd_busy;
  logic [WR-1:0]           wr_en;
  logic [WR-1:0][AW-1:0]   wr_addr;
  logic [WR-1:0][W-1:0]    wr_data;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;
  logic [NR-1:0]           busy_vec;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e;

  regfile_mp #(
    .WORD_SIZE (W),
    .NUM_REGS  (NR),
    .NUM_RD    (RD),
    .NUM_WR    (WR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst      = 1'b0;
    rd_en    = '0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a,
                    input logic [W-1:0] d, input logic b);
    exp_t x;
    rd_en[p]   = 1'b1;
    rd_addr[p] = a;
    x.port = p; x.data = d; x.busy = b;
    q.push_back(x);
  endtask

  task automatic wr(input int j, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en[j]   = 1'b1;
    wr_addr[j] = a;
    wr_data[j] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    step(); step();
    idle();
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec got %h want 0", busy_vec); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (rd_busy !== '0) begin errors++; $display("FAIL reset_rd_busy got %b want 0", rd_busy); end
    wr(0, 5'd5, 32'hDEADBEEF); rsv(5'd5);
    step(); idle();
    checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL pre_reset_busy got %h want 00000020", busy_vec); end
    // reset also discards a same-cycle write/reserve/read
    rst = 1'b1; wr(0, 5'd6, 32'h99); rsv(5'd6); rd_en = '1; rd_addr[0] = 5'd5;
    step(); idle();
    checks++; if (rd_data[0] !== '0) begin errors++; $display("FAIL reset_read_dropped got %h want 0", rd_data[0]); end
    rd(0, 5'd5, 32'h0, 1'b0); rd(1, 5'd6, 32'h0, 1'b0);
    step(); idle();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL reset_read data[%0d] got %h want %h", e.port, rd_data[e.port], e.data); end
      checks++; if (rd_busy[e.port] !== e.busy) begin errors++; $display("FAIL reset_read busy[%0d] got %b want %b", e.port, rd_busy[e.port], e.busy); end
    end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_after got %h want 0", busy_vec); end
  endtask

  task automatic test_zero_reg();
    idle();
    wr(0, 5'd0, 32'h1234); wr(1, 5'd0, 32'h5678); rsv(5'd0);
    rd(0, 5'd0, 32'h0, 1'b0); rd(1, 5'd0, 32'h0, 1'b0);
    step(); idle();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL zero_bypass data[%0d] got %h want %h", e.port, rd_data[e.port], e.data); end
      checks++; if (rd_busy[e.port] !== e.busy) begin errors++; $display("FAIL zero_bypass busy[%0d] got %b want %b", e.port, rd_busy[e.port], e.busy); end
    end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL zero_busy_vec got %h want 0", busy_vec); end
    rd(0, 5'd0, 32'h0, 1'b0); rd(1, 5'd0, 32'h0, 1'b0);
    step(); idle();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL zero_array data[%0d] got %h want %h", e.port, rd_data[e.port], e.data); end
      checks++; if (rd_busy[e.port] !== e.busy) begin errors++; $display("FAIL zero_array busy[%0d] got %b want %b", e.port, rd_busy[e.port], e.busy); end
    end
  endtask

  task automatic test_bypass();
    idle();
    wr(0, 5'd3, 32'hA5A5A5A5); rd(0, 5'd3, 32'hA5A5A5A5, 1'b0);
    step(); idle();
    rd(1, 5'd3, 32'hA5A5A5A5, 1'b0);
    // port 0 is idle this cycle and must hold its bypassed value
    e.port = 0; e.data = 32'hA5A5A5A5; e.busy = 1'b0; q.push_back(e);
    while (q.size() > 2) begin
      e = q.pop_front();
      checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL bypass_same data[%0d] got %h want %h", e.port, rd_data[e.port], e.data); end
    end
    step(); idle();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL bypass_next data[%0d] got %h want %h", e.port, rd_data[e.port], e.data); end
      checks++; if (rd_busy[e.port] !== e.busy) begin errors++; $display("FAIL bypass_next busy[%0d] got %b want %b", e.port, rd_busy[e.port], e.busy); end
    end
  endtask

  task automatic test_write_conflict();
    idle();
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7, 32'h22, 1'b0);
    step(); idle();
    rd(1, 5'd7, 32'h22, 1'b0);
    e = q.pop_front();
    checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL conflict_bypass got %h want %h", rd_data[e.port], e.data); end
    step(); idle();
    e = q.pop_front();
    checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL conflict_array got %h want %h", rd_data[e.port], e.data); end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv(5'd9); rd(0, 5'd9, 32'h0, 1'b1);
    step(); idle();
    checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sb_rsv busy_vec got %h want 00000200", busy_vec); end
    e = q.pop_front();
    checks++; if (rd_busy[0] !== e.busy) begin errors++; $display("FAIL sb_rsv rd_busy got %b want %b", rd_busy[0], e.busy); end
    wr(0, 5'd9, 32'h55); rd(1, 5'd9, 32'h55, 1'b0);
    step(); idle();
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL sb_clear busy_vec got %h want 0", busy_vec); end
    e = q.pop_front();
    checks++; if (rd_data[1] !== e.data) begin errors++; $display("FAIL sb_clear data got %h want %h", rd_data[1], e.data); end
    checks++; if (rd_busy[1] !== e.busy) begin errors++; $display("FAIL sb_clear rd_busy got %b want %b", rd_busy[1], e.busy); end
    rsv(5'd9); wr(1, 5'd9, 32'h66); wr(0, 5'd10, 32'h70);
    step(); idle();
    checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sb_both busy_vec got %h want 00000200", busy_vec); end
    rd(0, 5'd9, 32'h66, 1'b1); rd(1, 5'd10, 32'h70, 1'b0); rsv(5'd9);
    step(); idle();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL sb_both data[%0d] got %h want %h", e.port, rd_data[e.port], e.data); end
      checks++; if (rd_busy[e.port] !== e.busy) begin errors++; $display("FAIL sb_both busy[%0d] got %b want %b", e.port, rd_busy[e.port], e.busy); end
    end
    checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sb_rersv busy_vec got %h want 00000200", busy_vec); end
    wr(0, 5'd9, 32'h67);
    step(); idle();
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL sb_final busy_vec got %h want 0", busy_vec); end
  endtask

  task automatic test_read_hold();
    idle();
    wr(0, 5'd4, 32'h77);
    step(); idle();
    rd(0, 5'd4, 32'h77, 1'b0);
    step(); idle();
    e = q.pop_front();
    checks++; if (rd_data[0] !== e.data) begin errors++; $display("FAIL hold_capture got %h want %h", rd_data[0], e.data); end
    wr(0, 5'd4, 32'h88);
    step(); idle();
    checks++; if (rd_data[0] !== 32'h77) begin errors++; $display("FAIL hold_during_write got %h want 00000077", rd_data[0]); end
    step();
    checks++; if (rd_data[0] !== 32'h77) begin errors++; $display("FAIL hold_idle got %h want 00000077", rd_data[0]); end
    rd(0, 5'd4, 32'h88, 1'b0);
    step(); idle();
    e = q.pop_front();
    checks++; if (rd_data[0] !== e.data) begin errors++; $display("FAIL hold_reread got %h want %h", rd_data[0], e.data); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    logic [W-1:0] n_regs [NR];
    logic [NR-1:0] n_busy;
    logic [W-1:0] last_d [RD];
    logic         last_b [RD];
    exp_t x;
    idle(); rst = 1'b1;
    step(); idle();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int i = 0; i < RD; i++) begin last_d[i] = '0; last_b[i] = 1'b0; end
    for (int c = 0; c < 300; c++) begin
      idle();
      rst = ($urandom_range(0, 40) == 0);
      for (int j = 0; j < WR; j++) begin
        wr_en[j]   = 1'($urandom_range(0, 1));
        wr_addr[j] = AW'($urandom_range(0, 7));
        wr_data[j] = $urandom;
      end
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      for (int r = 0; r < NR; r++) begin
        n_regs[r] = m_regs[r];
        n_busy[r] = m_busy[r];
        for (int j = 0; j < WR; j++) begin
          if (wr_en[j] && wr_addr[j] == AW'(r)) begin
            n_regs[r] = wr_data[j];
            n_busy[r] = 1'b0;
          end
        end
        if (rsv_en && rsv_addr == AW'(r)) n_busy[r] = 1'b1;
        if (r == 0 || rst) begin n_regs[r] = '0; n_busy[r] = 1'b0; end
      end
      for (int i = 0; i < RD; i++) begin
        rd_en[i]   = 1'($urandom_range(0, 1));
        rd_addr[i] = AW'($urandom_range(0, 7));
        if (rst) begin
          last_d[i] = '0; last_b[i] = 1'b0;
        end else if (rd_en[i]) begin
          last_d[i] = n_regs[rd_addr[i]]; last_b[i] = n_busy[rd_addr[i]];
        end
        x.port = i; x.data = last_d[i]; x.busy = last_b[i];
        q.push_back(x);
      end
      for (int r = 0; r < NR; r++) m_regs[r] = n_regs[r];
      m_busy = n_busy;
      step();
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++; if (rd_data[e.port] !== e.data) begin errors++; $display("FAIL b2b cyc %0d data[%0d] got %h want %h", c, e.port, rd_data[e.port], e.data); end
        checks++; if (rd_busy[e.port] !== e.busy) begin errors++; $display("FAIL b2b cyc %0d busy[%0d] got %b want %b", c, e.port, rd_busy[e.port], e.busy); end
      end
      checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL b2b cyc %0d busy_vec got %h want %h", c, busy_vec, m_busy); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_write_conflict();
    test_scoreboard();
    test_read_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
